// File: rtl/hit_reduce_accum_pkg.sv
// Shared types and helpers for the hit reducer: fixed-point T, HitData,
// per-stage sideband record and the strict-compare min used by every stage.
package hit_reduce_accum_pkg;

   localparam int unsigned FIXED_W = 32;

   typedef logic signed [FIXED_W-1:0] Fixed;

   typedef struct packed {
      logic        bHit;
      Fixed        T;
      logic [15:0] PI;
      logic [3:0]  SurfaceType;
      logic [23:0] Color;
   } HitData;

   typedef struct packed {
      logic   valid;
      logic   last;
      logic   mode_any;
      Fixed   max_t;
      HitData h;
   } HitReduceStage;

   function automatic Fixed FixedInf();
      return Fixed'({1'b0, {(FIXED_W-1){1'b1}}});
   endfunction

   function automatic logic Fixed_Greater(input Fixed a, input Fixed b);
      return a > b;
   endfunction

   // Empty candidate: no hit, T at infinity.
   function automatic HitData hit_none();
      HitData h;
      h   = '0;
      h.T = FixedInf();
      return h;
   endfunction

   // Right operand wins only on a strictly smaller T, so ties keep the left one.
   function automatic HitData hit_min(input HitData a, input HitData b);
      return (b.bHit && Fixed_Greater(a.T, b.T)) ? b : a;
   endfunction

endpackage

// File: rtl/hit_reduce_accum_if.sv
// Beat input stream and result output stream of the hit reducer.
interface hit_reduce_accum_if
   import hit_reduce_accum_pkg::*;
#(
   parameter int unsigned LANES = 8,
   parameter int unsigned T_W   = FIXED_W
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_last;
   logic                 mode_any;
   logic [T_W-1:0]       max_t;
   HitData [LANES-1:0]   in_hit;
   logic                 out_valid;
   logic                 out_ready;
   HitData               out_hit;

   modport master (
      output in_valid, in_last, mode_any, max_t, in_hit, out_ready,
      input  in_ready, out_valid, out_hit
   );

   modport slave (
      input  in_valid, in_last, mode_any, max_t, in_hit, out_ready,
      output in_ready, out_valid, out_hit
   );
endinterface

// File: rtl/hit_min_stage.sv
// One registered comparator-tree level: N candidates reduced pairwise to N/2,
// carrying the beat sideband alongside. Freezes on stall, drops on flush.
module hit_min_stage
   import hit_reduce_accum_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               stall,
   input  logic               flush,
   input  logic               src_valid,
   input  logic               src_last,
   input  logic               src_mode_any,
   input  Fixed               src_max_t,
   input  HitData [N-1:0]     src_h,
   output logic               dst_valid,
   output logic               dst_last,
   output logic               dst_mode_any,
   output Fixed               dst_max_t,
   output HitData [N/2-1:0]   dst_h
);

   HitData [N/2-1:0] pair_min;

   // Pairwise strict min; lower lane is the left operand so ties go to it.
   always_comb begin
      pair_min = '0;
      for (int unsigned i = 0; i < N/2; i++) begin
         pair_min[i] = hit_min(src_h[2*i], src_h[2*i+1]);
      end
   end

   // Stage valid: flush wins over stall.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dst_valid <= 1'b0;
      end else if (flush) begin
         dst_valid <= 1'b0;
      end else if (!stall) begin
         dst_valid <= src_valid;
      end
   end

   // Stage payload and sideband.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dst_last     <= 1'b0;
         dst_mode_any <= 1'b0;
         dst_max_t    <= '0;
         dst_h        <= '0;
      end else if (!stall) begin
         dst_last     <= src_last;
         dst_mode_any <= src_mode_any;
         dst_max_t    <= src_max_t;
         dst_h        <= pair_min;
      end
   end

endmodule

// File: rtl/hit_reduce_accum.sv
// Closest-/any-hit reducer: qualifies LANES candidates per beat, reduces them
// through a registered min tree, folds beats into a per-ray best and emits one
// HitData per ray under valid/ready.
module hit_reduce_accum
   import hit_reduce_accum_pkg::*;
#(
   parameter int unsigned LANES = 8,
   parameter int unsigned T_W   = FIXED_W
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               flush,
   hit_reduce_accum_if.slave  bus
);

   localparam int unsigned LEVELS = $clog2(LANES);
   localparam int unsigned NODES  = 2*LANES - 1;

   // Tree nodes packed level after level: level l occupies LANES>>l entries.
   HitData [NODES-1:0]  node;
   HitData [LANES-1:0]  lane_q;
   logic   [LEVELS:0]   sb_valid;
   logic   [LEVELS:0]   sb_last;
   logic   [LEVELS:0]   sb_mode;
   Fixed   [LEVELS:0]   sb_max_t;

   logic           stall;
   logic           accept;
   logic           in_first;
   logic           ray_mode;
   Fixed           ray_max_t;
   logic [T_W-1:0] max_raw;
   Fixed           eff_max_t;

   HitReduceStage  beat;
   HitData         beat_h;
   HitData         acc;
   HitData         acc_next;
   logic           acc_first;
   logic           done;

   assign stall        = bus.out_valid && !bus.out_ready && done;
   assign bus.in_ready = !stall;
   assign accept       = bus.in_valid && !stall;
   assign max_raw      = bus.max_t;
   assign eff_max_t    = in_first ? Fixed'(max_raw) : ray_max_t;

   // Latch mode/max_t on the first beat of each ray and track ray boundaries.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         in_first  <= 1'b1;
         ray_mode  <= 1'b0;
         ray_max_t <= FixedInf();
      end else if (flush) begin
         in_first  <= 1'b1;
      end else if (accept) begin
         in_first <= bus.in_last;
         if (in_first) begin
            ray_mode  <= bus.mode_any;
            ray_max_t <= Fixed'(max_raw);
         end
      end
   end

   // Lane qualify: a lane counts only with bHit and T <= max_t.
   always_comb begin
      lane_q = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         lane_q[i] = bus.in_hit[i];
         if (!bus.in_hit[i].bHit || Fixed_Greater(bus.in_hit[i].T, eff_max_t)) begin
            lane_q[i].bHit = 1'b0;
            lane_q[i].T    = FixedInf();
         end
      end
   end

   assign node[LANES-1:0] = lane_q;
   assign sb_valid[0]     = accept;
   assign sb_last[0]      = bus.in_last;
   assign sb_mode[0]      = in_first ? bus.mode_any : ray_mode;
   assign sb_max_t[0]     = eff_max_t;

   for (genvar l = 0; l < LEVELS; l++) begin : g_level
      localparam int unsigned W   = LANES >> l;
      localparam int unsigned SRC = 2*LANES - 2*W;
      localparam int unsigned DST = SRC + W;

      hit_min_stage #(.N(W)) u_stage (
         .clk          (clk),
         .resetn       (resetn),
         .stall        (stall),
         .flush        (flush),
         .src_valid    (sb_valid[l]),
         .src_last     (sb_last[l]),
         .src_mode_any (sb_mode[l]),
         .src_max_t    (sb_max_t[l]),
         .src_h        (node[SRC +: W]),
         .dst_valid    (sb_valid[l+1]),
         .dst_last     (sb_last[l+1]),
         .dst_mode_any (sb_mode[l+1]),
         .dst_max_t    (sb_max_t[l+1]),
         .dst_h        (node[DST +: W/2])
      );
   end

   // Fold the beat minimum into the running best; any mode freezes after a hit.
   always_comb begin
      beat          = '0;
      beat.valid    = sb_valid[LEVELS];
      beat.last     = sb_last[LEVELS];
      beat.mode_any = sb_mode[LEVELS];
      beat.max_t    = sb_max_t[LEVELS];
      beat.h        = node[NODES-1];
      beat_h        = beat.h;
      // max_t re-check keeps the fold correct on its own, independent of the tree.
      if (!beat_h.bHit || Fixed_Greater(beat_h.T, beat.max_t)) begin
         beat_h.bHit = 1'b0;
         beat_h.T    = FixedInf();
      end
      if (acc_first) begin
         acc_next = beat_h;
      end else if (beat.mode_any && acc.bHit) begin
         acc_next = acc;
      end else begin
         acc_next = hit_min(acc, beat_h);
      end
   end

   // Accumulate stage; done marks that acc holds a finished ray.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc       <= hit_none();
         acc_first <= 1'b1;
         done      <= 1'b0;
      end else if (flush) begin
         acc       <= hit_none();
         acc_first <= 1'b1;
         done      <= 1'b0;
      end else if (!stall) begin
         done <= beat.valid && beat.last;
         if (beat.valid) begin
            acc       <= acc_next;
            acc_first <= beat.last;
         end
      end
   end

   // Result register: reloads in the same cycle as a handshake, kept across flush.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.out_valid <= 1'b0;
         bus.out_hit   <= '0;
      end else if (done && !stall && !flush) begin
         bus.out_valid <= 1'b1;
         bus.out_hit   <= acc;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hit_reduce_accum.sv
// Directed bench for hit_reduce_accum with LANES=8.
module tb_hit_reduce_accum;
   import hit_reduce_accum_pkg::*;

   typedef logic [127:0]   word_t;
   typedef HitData [7:0]   lanes_t;

   logic clk = 1'b0;
   logic resetn;
   logic flush;

   int unsigned total = 0;
   int unsigned bad   = 0;
   HitData      got_q[$];

   hit_reduce_accum_if #(.LANES(8), .T_W(32)) bus ();

   hit_reduce_accum #(.LANES(8), .T_W(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .flush  (flush),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Record every result handshake; out_ready is stable around the negedge.
   always @(negedge clk) begin
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_hit);
   end

   task automatic check(input string tag, input word_t got, input word_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic Fixed fx(input int v);
      return Fixed'(v <<< 16);
   endfunction

   function automatic HitData mk(input logic b, input Fixed t, input logic [15:0] pi);
      HitData r;
      r.bHit        = b;
      r.T           = t;
      r.PI          = pi;
      r.SurfaceType = pi[3:0];
      r.Color       = {8'hC0, pi};
      return r;
   endfunction

   // Non-hit lanes carry T=0 so a broken qualifier would let them win.
   function automatic lanes_t blank();
      lanes_t b;
      for (int i = 0; i < 8; i++) b[i] = mk(1'b0, '0, 16'hEE00 + 16'(i));
      return b;
   endfunction

   task automatic send_beat(input lanes_t h, input logic last, input logic any, input Fixed mt);
      int n;
      bus.in_hit   = h;
      bus.in_last  = last;
      bus.mode_any = any;
      bus.max_t    = mt;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("in_ready_wait", word_t'(bus.in_ready), 1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic get_result(output HitData r);
      int n = 0;
      while (got_q.size() == 0 && n < 100) begin
         tick();
         n++;
      end
      if (got_q.size() == 0) begin
         check("result_wait", word_t'(got_q.size()), 1);
         r = '0;
      end else begin
         r = got_q.pop_front();
      end
   endtask

   initial begin
      lanes_t h;
      HitData r;
      int     cnt;
      logic   seen;

      resetn        = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.mode_any  = 1'b0;
      bus.max_t     = FixedInf();
      bus.in_hit    = '0;
      bus.out_ready = 1'b1;
      #2 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", word_t'(bus.out_valid), 0);
      check("rst_out_hit",   word_t'(bus.out_hit),   0);
      check("rst_in_ready",  word_t'(bus.in_ready),  1);
      resetn = 1'b1;
      tick();

      // 1: single beat, closest, latency
      h = blank();
      h[3] = mk(1'b1, fx(5), 16'h0003);
      h[6] = mk(1'b1, fx(2), 16'h0006);
      send_beat(h, 1'b1, 1'b0, FixedInf());
      cnt = 0;
      while (!bus.out_valid && cnt < 20) begin
         tick();
         cnt++;
      end
      check("t1_latency", word_t'(cnt), 4);
      check("t1_hit", word_t'(bus.out_hit), word_t'(mk(1'b1, fx(2), 16'h0006)));
      get_result(r);
      check("t1_pop", word_t'(r), word_t'(mk(1'b1, fx(2), 16'h0006)));

      // 2: ties inside a beat and across beats
      h = blank();
      h[1] = mk(1'b1, fx(3), 16'h0001);
      h[5] = mk(1'b1, fx(3), 16'h0005);
      send_beat(h, 1'b1, 1'b0, FixedInf());
      get_result(r);
      check("t2_lane_tie", word_t'(r), word_t'(mk(1'b1, fx(3), 16'h0001)));
      h = blank();
      h[4] = mk(1'b1, fx(3), 16'h0004);
      send_beat(h, 1'b0, 1'b0, FixedInf());
      h = blank();
      h[2] = mk(1'b1, fx(3), 16'h0012);
      send_beat(h, 1'b1, 1'b0, FixedInf());
      get_result(r);
      check("t2_beat_tie", word_t'(r), word_t'(mk(1'b1, fx(3), 16'h0004)));

      // 3: three beats under max_t
      for (int pass = 0; pass < 2; pass++) begin
         h = blank();
         h[0] = mk(1'b1, fx(7), 16'h0000);
         send_beat(h, 1'b0, 1'b0, (pass == 0) ? fx(5) : fx(3));
         h = blank();
         h[5] = mk(1'b1, fx(4), 16'h0015);
         h[1] = mk(1'b1, fx(6), 16'h0011);
         send_beat(h, 1'b0, 1'b0, (pass == 0) ? fx(5) : FixedInf());
         h = blank();
         h[7] = mk(1'b1, fx(9), 16'h0027);
         send_beat(h, 1'b1, 1'b0, (pass == 0) ? fx(5) : FixedInf());
         get_result(r);
         if (pass == 0) begin
            check("t3_best", word_t'(r), word_t'(mk(1'b1, fx(4), 16'h0015)));
         end else begin
            check("t3_nohit_b", word_t'(r.bHit), 0);
            check("t3_nohit_t", word_t'(r.T), word_t'(FixedInf()));
         end
      end

      // 4: any mode keeps the first found hit; later mode input ignored
      h = blank();
      h[2] = mk(1'b1, fx(8), 16'h0002);
      send_beat(h, 1'b0, 1'b1, FixedInf());
      h = blank();
      h[0] = mk(1'b1, fx(1), 16'h0010);
      send_beat(h, 1'b1, 1'b0, FixedInf());
      get_result(r);
      check("t4_any", word_t'(r), word_t'(mk(1'b1, fx(8), 16'h0002)));
      repeat (8) tick();
      check("t4_one_result", word_t'(got_q.size()), 0);

      // 5: back-to-back rays under backpressure
      bus.out_ready = 1'b0;
      h = blank(); h[0] = mk(1'b1, fx(1), 16'h00A1);
      send_beat(h, 1'b1, 1'b0, FixedInf());
      h = blank(); h[1] = mk(1'b1, fx(2), 16'h00B2);
      send_beat(h, 1'b1, 1'b0, FixedInf());
      h = blank(); h[2] = mk(1'b1, fx(3), 16'h00C3);
      send_beat(h, 1'b1, 1'b0, FixedInf());
      tick();
      check("t5_ready_early", word_t'(bus.in_ready), 1);
      tick();
      check("t5_ready_drop", word_t'(bus.in_ready), 0);
      check("t5_first_out", word_t'(bus.out_hit), word_t'(mk(1'b1, fx(1), 16'h00A1)));
      repeat (4) tick();
      check("t5_ready_hold", word_t'(bus.in_ready), 0);
      bus.out_ready = 1'b1;
      tick();
      check("t5_reload_valid", word_t'(bus.out_valid), 1);
      check("t5_reload_hit", word_t'(bus.out_hit), word_t'(mk(1'b1, fx(2), 16'h00B2)));
      get_result(r);
      check("t5_order_a", word_t'(r.PI), 16'h00A1);
      get_result(r);
      check("t5_order_b", word_t'(r.PI), 16'h00B2);
      get_result(r);
      check("t5_order_c", word_t'(r.PI), 16'h00C3);
      repeat (8) tick();
      check("t5_no_dup", word_t'(got_q.size()), 0);

      // 6: flush mid-ray, then a fresh ray
      h = blank(); h[0] = mk(1'b1, fx(1), 16'h0061);
      send_beat(h, 1'b0, 1'b0, FixedInf());
      h = blank(); h[3] = mk(1'b1, fx(1), 16'h0062);
      send_beat(h, 1'b0, 1'b0, FixedInf());
      flush = 1'b1;
      tick();
      flush = 1'b0;
      h = blank(); h[4] = mk(1'b1, fx(2), 16'h0077);
      send_beat(h, 1'b1, 1'b0, FixedInf());
      get_result(r);
      check("t6_flush", word_t'(r), word_t'(mk(1'b1, fx(2), 16'h0077)));
      repeat (8) tick();
      check("t6_only_one", word_t'(got_q.size()), 0);

      // 6b: asynchronous reset mid-ray discards everything
      h = blank(); h[0] = mk(1'b1, fx(1), 16'h0091);
      send_beat(h, 1'b0, 1'b0, FixedInf());
      h = blank(); h[1] = mk(1'b1, fx(2), 16'h0092);
      send_beat(h, 1'b1, 1'b0, FixedInf());
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.out_valid) seen = 1'b1;
      end
      check("rst2_no_out", word_t'(seen), 0);
      check("rst2_hit", word_t'(bus.out_hit), 0);
      check("rst2_queue", word_t'(got_q.size()), 0);
      check("rst2_ready", word_t'(bus.in_ready), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
